// File: rtl/led_fade_pwm_if.sv
// led_fade_pwm_if
//   Bundles the LED pattern request and the LED drive/status signals of the
//   fade/PWM stage.
//   pattern_in    : requested LED states, bit i = LED i on
//   pattern_valid : load pattern_in into the target register this cycle
//   bypass        : drive LEDs straight from the target (no PWM/fade)
//   led_out       : registered LED drive
//   settled       : registered, 1 when every channel is fully OFF or fully ON
//   master = pattern producer / LED observer, slave = led_fade_pwm.
interface led_fade_pwm_if #(
    parameter int N_LEDS = 4
);
    logic [N_LEDS-1:0] pattern_in;
    logic              pattern_valid;
    logic              bypass;
    logic [N_LEDS-1:0] led_out;
    logic              settled;

    modport master (
        output pattern_in, pattern_valid, bypass,
        input  led_out, settled
    );

    modport slave (
        input  pattern_in, pattern_valid, bypass,
        output led_out, settled
    );
endinterface

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//   Turns hard on/off LED requests into PWM drives whose brightness ramps up
//   quickly on activation and decays slowly on deactivation ("comet tail").
//   Ports:
//     clk   : system clock
//     rst_n : asynchronous active-low reset
//     bus   : led_fade_pwm_if slave (pattern_in, pattern_valid, bypass in;
//             led_out, settled out)
module led_fade_pwm #(
    parameter int N_LEDS    = 4,
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 4096,
    parameter int UP_STEP   = 32,
    parameter int DOWN_STEP = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    led_fade_pwm_if.slave bus
);
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam int                  FC_W      = $clog2(FADE_DIV);
    localparam logic [FC_W-1:0]     FADE_LAST = FC_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS:0]   UP_W      = (PWM_BITS + 1)'(UP_STEP);
    localparam logic [PWM_BITS:0]   DN_W      = (PWM_BITS + 1)'(DOWN_STEP);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RISE,
        ST_ON,
        ST_FALL
    } ch_state_t;

    logic [N_LEDS-1:0]   target_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [FC_W-1:0]     fade_cnt_q;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                settled_q, settled_d;
    logic                fade_tick;

    ch_state_t           state_q [N_LEDS];
    ch_state_t           state_d [N_LEDS];
    logic [PWM_BITS-1:0] level_q [N_LEDS];
    logic [PWM_BITS-1:0] level_d [N_LEDS];

    logic [PWM_BITS:0]   sum, dif;
    logic [PWM_BITS-1:0] up_lvl, dn_lvl;

    assign fade_tick = (fade_cnt_q == FADE_LAST);

    always_comb begin
        sum       = '0;
        dif       = '0;
        up_lvl    = '0;
        dn_lvl    = '0;
        settled_d = 1'b1;
        led_d     = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            state_d[i] = state_q[i];
            level_d[i] = level_q[i];

            // One extra bit catches overflow (add) and borrow (subtract).
            sum    = {1'b0, level_q[i]} + UP_W;
            dif    = {1'b0, level_q[i]} - DN_W;
            up_lvl = sum[PWM_BITS] ? MAX : sum[PWM_BITS-1:0];
            dn_lvl = dif[PWM_BITS] ? '0  : dif[PWM_BITS-1:0];

            if (fade_tick) begin
                case (state_q[i])
                    ST_OFF: begin
                        if (target_q[i]) begin
                            level_d[i] = up_lvl;
                            state_d[i] = (up_lvl == MAX) ? ST_ON : ST_RISE;
                        end
                    end
                    ST_ON: begin
                        if (!target_q[i]) begin
                            level_d[i] = dn_lvl;
                            state_d[i] = (dn_lvl == '0) ? ST_OFF : ST_FALL;
                        end
                    end
                    default: begin
                        if (target_q[i]) begin
                            level_d[i] = up_lvl;
                            state_d[i] = (up_lvl == MAX) ? ST_ON : ST_RISE;
                        end else begin
                            level_d[i] = dn_lvl;
                            state_d[i] = (dn_lvl == '0) ? ST_OFF : ST_FALL;
                        end
                    end
                endcase
            end

            if ((state_q[i] != ST_OFF) && (state_q[i] != ST_ON)) begin
                settled_d = 1'b0;
            end

            led_d[i] = bus.bypass ? target_q[i]
                                  : ((level_q[i] == MAX) || (level_q[i] > pwm_cnt_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            pwm_cnt_q  <= '0;
            fade_cnt_q <= '0;
            led_q      <= '0;
            settled_q  <= 1'b1;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                state_q[i] <= ST_OFF;
                level_q[i] <= '0;
            end
        end else begin
            if (bus.pattern_valid) begin
                target_q <= bus.pattern_in;
            end
            pwm_cnt_q  <= pwm_cnt_q + 1'b1;
            fade_cnt_q <= fade_tick ? '0 : fade_cnt_q + 1'b1;
            led_q      <= led_d;
            settled_q  <= settled_d;
            for (int unsigned i = 0; i < N_LEDS; i++) begin
                state_q[i] <= state_d[i];
                level_q[i] <= level_d[i];
            end
        end
    end

    assign bus.led_out = led_q;
    assign bus.settled = settled_q;
endmodule
